nw_traceback_ctrl: RTL and testbench

Traceback sequencer for the Needleman-Wunsch datapath. After the score/direction matrix is filled, it walks the direction RAM from cell (len_a, len_b) back to (0,0), fetches the matching symbols from the two input-sequence RAMs, and writes one aligned column per step into aligned RAMs A and B. It drives their write enables, the shared write index and the 3-bit symbol data, and reports the alignment length when finished.

---
 rtl/nw_traceback_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_nw_traceback_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/nw_traceback_ctrl.sv
// Needleman-Wunsch traceback sequencer: walks the direction RAM from (len_a, len_b) to (0,0)
// and emits one aligned column per step. Define TRACE_ERR_EN to abort on illegal direction 11.
module nw_traceback_ctrl #(
    parameter int unsigned N       = 128,
    parameter int unsigned BitAddr = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [BitAddr:0]   len_a,
    input  logic [BitAddr:0]   len_b,
    output logic [BitAddr:0]   dir_i,
    output logic [BitAddr:0]   dir_j,
    input  logic [1:0]         dir_data,
    output logic [BitAddr:0]   seq_a_addr,
    input  logic [2:0]         seq_a_data,
    output logic [BitAddr:0]   seq_b_addr,
    input  logic [2:0]         seq_b_data,
    output logic               en_traceA,
    output logic               en_traceB,
    output logic [BitAddr:0]   k,
    output logic [2:0]         sym_a,
    output logic [2:0]         sym_b,
    output logic               busy,
    output logic               done,
    output logic [BitAddr:0]   align_len,
    output logic               err
);

    localparam int unsigned W = BitAddr + 1;

    localparam logic [W-1:0] Zero = '0;
    localparam logic [W-1:0] One  = {{(W-1){1'b0}}, 1'b1};

    localparam logic [1:0] DirDiag = 2'b00;
    localparam logic [1:0] DirUp   = 2'b01;
    localparam logic [1:0] DirLeft = 2'b10;
    localparam logic [1:0] DirBad  = 2'b11;

    localparam logic [2:0] SymGap = 3'b100;

    typedef enum logic [2:0] {
        StIdle,
        StRead,
        StWait,
        StWrite,
        StFin
    } state_e;

    state_e         state_q, state_d;
    logic [W-1:0]   i_q, i_d;
    logic [W-1:0]   j_q, j_d;
    logic [W-1:0]   k_q, k_d;
    logic [W-1:0]   a_addr_q, a_addr_d;
    logic [W-1:0]   b_addr_q, b_addr_d;
    logic [1:0]     dir_q, dir_d;
    logic           en_q, en_d;
    logic [2:0]     sym_a_q, sym_a_d;
    logic [2:0]     sym_b_q, sym_b_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic [W-1:0]   align_q, align_d;
    logic           err_q, err_d;
    logic [1:0]     eff_dir;

    // Matrix edges override the RAM: on row 0 only left moves remain, on column 0 only up moves.
    always_comb begin
        if (i_q == Zero) begin
            eff_dir = DirLeft;
        end else if (j_q == Zero) begin
            eff_dir = DirUp;
        end else begin
            eff_dir = dir_data;
        end
`ifndef TRACE_ERR_EN
        if (eff_dir == DirBad) begin
            eff_dir = DirDiag;
        end
`endif
    end

    always_comb begin
        state_d  = state_q;
        i_d      = i_q;
        j_d      = j_q;
        k_d      = k_q;
        a_addr_d = a_addr_q;
        b_addr_d = b_addr_q;
        dir_d    = dir_q;
        en_d     = 1'b0;
        sym_a_d  = sym_a_q;
        sym_b_d  = sym_b_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        align_d  = align_q;
        err_d    = err_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    i_d      = len_a;
                    j_d      = len_b;
                    k_d      = Zero;
                    a_addr_d = len_a - One;
                    b_addr_d = len_b - One;
                    err_d    = 1'b0;
                    busy_d   = 1'b1;
                    state_d  = StRead;
                end
            end

            StRead: begin
                if (i_q == Zero && j_q == Zero) begin
                    done_d  = 1'b1;
                    align_d = k_q;
                    state_d = StFin;
                end else begin
                    state_d = StWait;
                end
            end

            StWait: begin
                dir_d   = eff_dir;
                en_d    = 1'b1;
                sym_a_d = (eff_dir == DirLeft) ? SymGap : seq_a_data;
                sym_b_d = (eff_dir == DirUp)   ? SymGap : seq_b_data;
                state_d = StWrite;
`ifdef TRACE_ERR_EN
                if (eff_dir == DirBad) begin
                    dir_d   = dir_q;
                    en_d    = 1'b0;
                    sym_a_d = sym_a_q;
                    sym_b_d = sym_b_q;
                    err_d   = 1'b1;
                    done_d  = 1'b1;
                    align_d = k_q;
                    state_d = StFin;
                end
`endif
            end

            StWrite: begin
                k_d = k_q + One;
                if (dir_q != DirLeft && i_q != Zero) begin
                    i_d = i_q - One;
                end
                if (dir_q != DirUp && j_q != Zero) begin
                    j_d = j_q - One;
                end
                a_addr_d = i_d - One;
                b_addr_d = j_d - One;
                state_d  = StRead;
            end

            StFin: begin
                busy_d  = 1'b0;
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            i_q      <= '0;
            j_q      <= '0;
            k_q      <= '0;
            a_addr_q <= '0;
            b_addr_q <= '0;
            dir_q    <= DirDiag;
            en_q     <= 1'b0;
            sym_a_q  <= '0;
            sym_b_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            align_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            i_q      <= i_d;
            j_q      <= j_d;
            k_q      <= k_d;
            a_addr_q <= a_addr_d;
            b_addr_q <= b_addr_d;
            dir_q    <= dir_d;
            en_q     <= en_d;
            sym_a_q  <= sym_a_d;
            sym_b_q  <= sym_b_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            align_q  <= align_d;
            err_q    <= err_d;
        end
    end

    assign dir_i      = i_q;
    assign dir_j      = j_q;
    assign seq_a_addr = a_addr_q;
    assign seq_b_addr = b_addr_q;
    assign en_traceA  = en_q;
    assign en_traceB  = en_q;
    assign k          = k_q;
    assign sym_a      = sym_a_q;
    assign sym_b      = sym_b_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign align_len  = align_q;
    assign err        = err_q;

endmodule

// File: tb/tb_nw_traceback_ctrl.sv
// Self-checking bench for nw_traceback_ctrl: a reference walk pushes expected columns to a
// scoreboard queue, which is popped on every write strobe. Honours TRACE_ERR_EN.
module tb_nw_traceback_ctrl;

    localparam int N = 128;
    localparam int BitAddr = $clog2(N);
    localparam int W = BitAddr + 1;

    typedef struct packed {
        logic [W-1:0] k;
        logic [2:0]   a;
        logic [2:0]   b;
    } wr_t;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [W-1:0]   len_a, len_b;
    logic [W-1:0]   dir_i, dir_j;
    logic [1:0]     dir_data;
    logic [W-1:0]   seq_a_addr, seq_b_addr;
    logic [2:0]     seq_a_data, seq_b_data;
    logic           en_traceA, en_traceB;
    logic [W-1:0]   k;
    logic [2:0]     sym_a, sym_b;
    logic           busy, done, err;
    logic [W-1:0]   align_len;

    logic [1:0] dir_mem [0:N][0:N];
    logic [2:0] a_mem [0:N-1];
    logic [2:0] b_mem [0:N-1];

    wr_t q[$];
    int checks = 0;
    int errors = 0;

    nw_traceback_ctrl #(.N(N)) dut (
        .clk(clk), .rst(rst), .start(start), .len_a(len_a), .len_b(len_b),
        .dir_i(dir_i), .dir_j(dir_j), .dir_data(dir_data),
        .seq_a_addr(seq_a_addr), .seq_a_data(seq_a_data),
        .seq_b_addr(seq_b_addr), .seq_b_data(seq_b_data),
        .en_traceA(en_traceA), .en_traceB(en_traceB), .k(k),
        .sym_a(sym_a), .sym_b(sym_b), .busy(busy), .done(done),
        .align_len(align_len), .err(err)
    );

    always #5 clk = ~clk;

    // Synchronous-read RAM models, one cycle latency.
    always @(posedge clk) begin
        dir_data   <= dir_mem[dir_i][dir_j];
        seq_a_data <= (int'(seq_a_addr) < N) ? a_mem[seq_a_addr] : 3'b000;
        seq_b_data <= (int'(seq_b_addr) < N) ? b_mem[seq_b_addr] : 3'b000;
    end

    task automatic fill_dir(input logic [1:0] v);
        for (int r = 0; r <= N; r++)
            for (int c = 0; c <= N; c++)
                dir_mem[r][c] = v;
    endtask

    task automatic fill_seq();
        for (int x = 0; x < N; x++) begin
            a_mem[x] = 3'($urandom_range(0, 3));
            b_mem[x] = 3'($urandom_range(0, 3));
        end
    endtask

    function automatic logic [W*3+3:0] all_outputs();
        return {dir_i, dir_j, seq_a_addr, seq_b_addr, en_traceA, en_traceB, k, sym_a, sym_b,
                busy, done, align_len, err};
    endfunction

    // Reference traceback; pushes expected columns, returns count, final k and error flag.
    task automatic model(input int la, input int lb, output int cols, output logic [W-1:0] kk,
                         output logic xerr);
        int ii = la;
        int jj = lb;
        logic [1:0] d;
        wr_t w;
        cols = 0;
        kk = '0;
        xerr = 1'b0;
        while (ii != 0 || jj != 0) begin
            if (ii == 0) d = 2'b10;
            else if (jj == 0) d = 2'b01;
            else d = dir_mem[ii][jj];
            if (d == 2'b11) begin
`ifdef TRACE_ERR_EN
                xerr = 1'b1;
                break;
`else
                d = 2'b00;
`endif
            end
            w.k = kk;
            w.a = (d == 2'b10) ? 3'b100 : a_mem[ii-1];
            w.b = (d == 2'b01) ? 3'b100 : b_mem[jj-1];
            q.push_back(w);
            if (d != 2'b10) ii--;
            if (d != 2'b01) jj--;
            kk++;
            cols++;
        end
    endtask

    task automatic run_trace(input int la, input int lb, input string name);
        int cols;
        int exp_cyc;
        logic [W-1:0] exp_len;
        logic exp_err;
        logic got_done;
        wr_t w;
        model(la, lb, cols, exp_len, exp_err);
        exp_cyc = 3 * cols + 2 + (exp_err ? 1 : 0);
        start = 1'b1;
        len_a = W'(la);
        len_b = W'(lb);
        @(negedge clk);
        start = 1'b0;
        got_done = 1'b0;
        for (int c = 1; c <= 3 * (la + lb) + 10 && !got_done; c++) begin
            if (c == 1) begin
                checks++;
                if (busy !== 1'b1) begin
                    errors++;
                    $display("FAIL %s busy_after_start: got %b want 1", name, busy);
                end
            end
            if (en_traceA || en_traceB) begin
                checks++;
                if (q.size() == 0 || en_traceA !== en_traceB) begin
                    errors++;
                    $display("FAIL %s write: unexpected en=%b%b k=%0d", name, en_traceA, en_traceB,
                             k);
                end else begin
                    w = q.pop_front();
                    if ({k, sym_a, sym_b} !== {w.k, w.a, w.b}) begin
                        errors++;
                        $display("FAIL %s column: got k=%0d a=%0d b=%0d want k=%0d a=%0d b=%0d",
                                 name, k, sym_a, sym_b, w.k, w.a, w.b);
                    end
                end
            end
            if (done === 1'b1) begin
                got_done = 1'b1;
                checks++;
                if (align_len !== exp_len || c != exp_cyc || err !== exp_err || q.size() != 0) begin
                    errors++;
                    $display("FAIL %s done: got len=%0d cyc=%0d err=%b left=%0d want len=%0d cyc=%0d err=%b left=0",
                             name, align_len, c, err, q.size(), exp_len, exp_cyc, exp_err);
                end
            end
            @(negedge clk);
        end
        checks++;
        if (!got_done) begin
            errors++;
            $display("FAIL %s timeout: no done seen, want done at cycle %0d", name, exp_cyc);
        end else if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL %s after_done: got busy=%b done=%b want 0 0", name, busy, done);
        end
        q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        len_a = '0;
        len_b = '0;
        repeat (2) @(negedge clk);
        checks++;
        if (all_outputs() !== '0) begin
            errors++;
            $display("FAIL reset_state: got %h want 0", all_outputs());
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_diag();
        fill_dir(2'b00);
        for (int x = 0; x < 3; x++) begin
            a_mem[x] = 3'(x);
            b_mem[x] = 3'(x);
        end
        run_trace(3, 3, "diag3");
    endtask

    task automatic test_up_diag();
        fill_seq();
        fill_dir(2'b00);
        dir_mem[2][1] = 2'b01;
        run_trace(2, 1, "up_diag");
    endtask

    task automatic test_forced_left();
        fill_seq();
        fill_dir(2'b00);
        dir_mem[0][2] = 2'b11;
        dir_mem[0][1] = 2'b01;
        run_trace(1, 3, "forced_left");
    endtask

    task automatic test_max_len();
        fill_seq();
        fill_dir(2'b01);
        run_trace(N, N, "max_len");
    endtask

    task automatic test_reset_mid();
        fill_dir(2'b00);
        start = 1'b1;
        len_a = W'(3);
        len_b = W'(3);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (all_outputs() !== '0) begin
            errors++;
            $display("FAIL reset_mid_async: got %h want 0", all_outputs());
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_held: got done=%b busy=%b want 0 0", done, busy);
        end
        rst = 1'b0;
        @(negedge clk);
        run_trace(3, 3, "after_reset");
    endtask

    task automatic test_illegal_dir();
        fill_seq();
        fill_dir(2'b00);
        dir_mem[2][2] = 2'b11;
        run_trace(2, 2, "illegal_dir");
        fill_dir(2'b00);
        run_trace(2, 2, "err_cleared");
    endtask

    task automatic test_back_to_back();
        for (int t = 0; t < 4; t++) begin
            fill_seq();
            for (int r = 0; r <= 8; r++)
                for (int c = 0; c <= 8; c++)
                    dir_mem[r][c] = 2'($urandom_range(0, 3));
            run_trace($urandom_range(1, 8), $urandom_range(1, 8), "random");
        end
    endtask

    initial begin
        test_reset();
        test_diag();
        test_up_diag();
        test_forced_left();
        test_max_len();
        test_reset_mid();
        test_illegal_dir();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
